control_sequencer: RTL

- Hardwired control unit for the single-bus datapath.
- Steps each instruction through fetch and execute T-states and drives the per-state control strobes.
- Its gra/grb/grc/r_in/r_out/ba_out outputs feed the register select/encode stage directly.
- Covers the load/store/ALU subset plus nop/halt, with a memory-done handshake for wait states.

---
 rtl/control_sequencer.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: steps fetch/execute and decodes per-state datapath strobes.
// Latency: strobes are a combinational decode of the current T-state and ir[31:27]; one T-state per clk.
// Backpressure: memory states T1, ld-T6 and st-T7 stall until mem_done=1; no other flow control.
module control_sequencer #(
    parameter int REG_SIZE = 32,
    parameter int OPW      = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [REG_SIZE-1:0] ir,
    input  logic                mem_done,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic                r_in,
    output logic                r_out,
    output logic                ba_out,
    output logic                pc_out,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                mdr_rd,
    output logic                read,
    output logic                write,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlo_out,
    output logic                c_out,
    output logic [3:0]          alu_op,
    output logic                run,
    output logic                illegal
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    // Full control word for one T-state; unpacked onto the ports below.
    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       pc_out;
        logic       inc_pc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       mdr_rd;
        logic       read;
        logic       write;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       zlo_out;
        logic       c_out;
        logic [3:0] alu_op;
        logic       run;
        logic       illegal;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(7);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(8);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(9);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    state_t         state;
    state_t         state_nxt;
    ctrl_t          ctrl;
    logic [OPW-1:0] opcode;
    logic [OPW-1:0] op_rel;
    logic           is_reg;
    logic           is_imm;
    logic           is_ld;
    logic           is_st;
    logic           is_ldi;
    logic           is_nop;
    logic           is_halt;
    logic [3:0]     imm_alu;
    logic           unused_ir_fields;

    assign opcode           = ir[REG_SIZE-1 -: OPW];
    assign unused_ir_fields = &{1'b0, ir[REG_SIZE-OPW-1:0]};

    // Opcode class decode; register ALU ops map to alu_op = opcode-3.
    always_comb begin
        is_reg  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR);
        is_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
        is_ld   = (opcode == OP_LD);
        is_st   = (opcode == OP_ST);
        is_ldi  = (opcode == OP_LDI);
        is_nop  = (opcode == OP_NOP);
        is_halt = (opcode == OP_HALT);
        op_rel  = opcode - OP_ADD;
        imm_alu = ALU_ADD;
        if (opcode == OP_ANDI) begin
            imm_alu = ALU_AND;
        end else if (opcode == OP_ORI) begin
            imm_alu = ALU_OR;
        end
    end

    // State register; reset drops straight to IDLE so no strobe survives it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control-word decode; everything defaults to idle/zero.
    always_comb begin
        state_nxt = state;
        ctrl      = '0;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_T0;
            end
            S_T0: begin
                ctrl.run    = 1'b1;
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                state_nxt   = S_T1;
            end
            S_T1: begin
                ctrl.run    = 1'b1;
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
                ctrl.mdr_rd = 1'b1;
                if (mem_done) begin
                    state_nxt = S_T2;
                end
            end
            S_T2: begin
                ctrl.run     = 1'b1;
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                state_nxt    = S_T3;
            end
            S_T3: begin
                ctrl.run = 1'b1;
                if (is_reg || is_imm) begin
                    ctrl.grb   = 1'b1;
                    ctrl.r_out = 1'b1;
                    ctrl.y_in  = 1'b1;
                    state_nxt  = S_T4;
                end else if (is_ld || is_st || is_ldi) begin
                    ctrl.grb    = 1'b1;
                    ctrl.ba_out = 1'b1;
                    ctrl.y_in   = 1'b1;
                    state_nxt   = S_T4;
                end else if (is_nop) begin
                    state_nxt = S_T0;
                end else if (is_halt) begin
                    state_nxt = S_HALT;
                end else begin
                    ctrl.illegal = 1'b1;
                    state_nxt    = S_T0;
                end
            end
            S_T4: begin
                ctrl.run  = 1'b1;
                state_nxt = S_T5;
                if (is_reg) begin
                    ctrl.grc    = 1'b1;
                    ctrl.r_out  = 1'b1;
                    ctrl.z_in   = 1'b1;
                    ctrl.alu_op = op_rel[3:0];
                end else if (is_imm) begin
                    ctrl.c_out  = 1'b1;
                    ctrl.z_in   = 1'b1;
                    ctrl.alu_op = imm_alu;
                end else if (is_ld || is_st || is_ldi) begin
                    ctrl.c_out  = 1'b1;
                    ctrl.z_in   = 1'b1;
                    ctrl.alu_op = ALU_ADD;
                end else begin
                    // ir changed under us; abandon the instruction cleanly.
                    state_nxt = S_T0;
                end
            end
            S_T5: begin
                ctrl.run  = 1'b1;
                state_nxt = S_T0;
                if (is_ld || is_st) begin
                    ctrl.zlo_out = 1'b1;
                    ctrl.mar_in  = 1'b1;
                    state_nxt    = S_T6;
                end else if (is_reg || is_imm || is_ldi) begin
                    ctrl.zlo_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                end
            end
            S_T6: begin
                ctrl.run  = 1'b1;
                state_nxt = S_T0;
                if (is_ld) begin
                    ctrl.read   = 1'b1;
                    ctrl.mdr_in = 1'b1;
                    ctrl.mdr_rd = 1'b1;
                    state_nxt   = mem_done ? S_T7 : S_T6;
                end else if (is_st) begin
                    // mdr_rd stays 0 so MDR loads from the bus.
                    ctrl.gra    = 1'b1;
                    ctrl.r_out  = 1'b1;
                    ctrl.mdr_in = 1'b1;
                    state_nxt   = S_T7;
                end
            end
            S_T7: begin
                ctrl.run  = 1'b1;
                state_nxt = S_T0;
                if (is_ld) begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                end else if (is_st) begin
                    ctrl.write = 1'b1;
                    state_nxt  = mem_done ? S_T0 : S_T7;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign gra     = ctrl.gra;
    assign grb     = ctrl.grb;
    assign grc     = ctrl.grc;
    assign r_in    = ctrl.r_in;
    assign r_out   = ctrl.r_out;
    assign ba_out  = ctrl.ba_out;
    assign pc_out  = ctrl.pc_out;
    assign inc_pc  = ctrl.inc_pc;
    assign mar_in  = ctrl.mar_in;
    assign mdr_in  = ctrl.mdr_in;
    assign mdr_out = ctrl.mdr_out;
    assign mdr_rd  = ctrl.mdr_rd;
    assign read    = ctrl.read;
    assign write   = ctrl.write;
    assign ir_in   = ctrl.ir_in;
    assign y_in    = ctrl.y_in;
    assign z_in    = ctrl.z_in;
    assign zlo_out = ctrl.zlo_out;
    assign c_out   = ctrl.c_out;
    assign alu_op  = ctrl.alu_op;
    assign run     = ctrl.run;
    assign illegal = ctrl.illegal;

endmodule
